watch_fnd_ctrl: RTL and testbench

Display-side consumer of the watch time bus. Takes the live msec/sec/min/hour values and drives a 4-digit, common-anode 7-segment display by time-multiplexed digit scanning. A mode input selects which pair of fields is shown: hour:min or sec:msec. Sits between the watch datapath outputs and the board-level FND pins.

---
 rtl/watch_fnd_ctrl.sv | 127 ++++++++++++
 tb/tb_watch_fnd_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/watch_fnd_ctrl.sv
// watch_fnd_ctrl
// Drives a 4-digit common-anode 7-segment display from the watch time bus.
// Digits are scanned with time multiplexing. sw_mode selects the fields shown:
// hour:min (0) or sec:msec (1).
//
// Optional build macro: WATCH_FND_DP_BLINK_EN
//   When defined, the dp of digit 2 is lit while i_msec < 50. This gives a
//   1 Hz colon-style blink. When undefined, dp is always off.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   sw_mode  0 = hour:min, 1 = sec:msec
//   i_msec   0..99 (values 100..127 are displayed modulo 100)
//   i_sec    0..59
//   i_min    0..59
//   i_hour   0..23
//   fnd_com  digit enables, active-low, bit0 = rightmost digit
//   fnd_data bit7 = dp, bits6:0 = g..a, all active-low
module watch_fnd_ctrl #(
   parameter int unsigned SCAN_DIV        = 100_000,
   parameter bit          BLANK_HOUR_TENS = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_mode,
   input  logic [6:0] i_msec,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic [4:0] i_hour,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int unsigned   CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] scan_cnt;
   logic [1:0]    digit_idx;

   logic [6:0] lo_field;
   logic [6:0] hi_field;
   logic [6:0] lo_mod;
   logic [6:0] hi_mod;
   logic [3:0] digit;
   logic [6:0] seg;
   logic       dp;
   logic       blank;
   logic [3:0] com_next;
   logic [7:0] data_next;

   function automatic logic [6:0] mod100(input logic [6:0] v);
      return (v >= 7'd100) ? v - 7'd100 : v;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Scan timebase: digit_idx advances on the edge where the counter wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == CNT_LAST) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      lo_field = sw_mode ? i_msec        : {1'b0, i_min};
      hi_field = sw_mode ? {1'b0, i_sec} : {2'b00, i_hour};
      lo_mod   = mod100(lo_field);
      hi_mod   = mod100(hi_field);

      digit = '0;
      case (digit_idx)
         2'd0: digit = 4'(lo_mod % 7'd10);
         2'd1: digit = 4'(lo_mod / 7'd10);
         2'd2: digit = 4'(hi_mod % 7'd10);
         2'd3: digit = 4'(hi_mod / 7'd10);
         default: digit = '0;
      endcase
      seg = seg7(digit);

`ifdef WATCH_FND_DP_BLINK_EN
      dp = !((digit_idx == 2'd2) && (i_msec < 7'd50));
`else
      dp = 1'b1;
`endif

      // Blanking turns off the whole digit, dp included. The digit enable is
      // still driven.
      blank = BLANK_HOUR_TENS && !sw_mode && (digit_idx == 2'd3) && (i_hour < 5'd10);

      data_next = blank ? 8'hFF : {dp, seg};
      com_next  = ~(4'b0001 << digit_idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fnd_com  <= '1;
         fnd_data <= '1;
      end else begin
         fnd_com  <= com_next;
         fnd_data <= data_next;
      end
   end

endmodule

// File: tb/tb_watch_fnd_ctrl.sv
// tb_watch_fnd_ctrl
// Directed-vector bench for watch_fnd_ctrl with SCAN_DIV=4.
// It runs two instances: one with leading-hour blanking and one without.
// Expected dp depends on WATCH_FND_DP_BLINK_EN.
module tb_watch_fnd_ctrl;

   logic       clk;
   logic       rst;
   logic       sw_mode;
   logic [6:0] i_msec;
   logic [5:0] i_sec;
   logic [5:0] i_min;
   logic [4:0] i_hour;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;
   logic [3:0] fnd_com_nb;
   logic [7:0] fnd_data_nb;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   watch_fnd_ctrl #(.SCAN_DIV(4), .BLANK_HOUR_TENS(1'b1)) dut (
      .clk(clk), .rst(rst), .sw_mode(sw_mode), .i_msec(i_msec), .i_sec(i_sec),
      .i_min(i_min), .i_hour(i_hour), .fnd_com(fnd_com), .fnd_data(fnd_data)
   );

   watch_fnd_ctrl #(.SCAN_DIV(4), .BLANK_HOUR_TENS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .sw_mode(sw_mode), .i_msec(i_msec), .i_sec(i_sec),
      .i_min(i_min), .i_hour(i_hour), .fnd_com(fnd_com_nb), .fnd_data(fnd_data_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [6:0]  msec;
      logic [5:0]  sec;
      logic [5:0]  min;
      logic [4:0]  hour;
      int unsigned idx;
      logic [7:0]  exp_data;
      logic [7:0]  exp_data_nb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic mode, input int msec, input int sec,
                               input int min, input int hour, input int unsigned idx,
                               input logic [7:0] e, input logic [7:0] e_nb);
      vec_t v;
      v.mode = mode;
      v.msec = 7'(msec);
      v.sec = 6'(sec);
      v.min = 6'(min);
      v.hour = 5'(hour);
      v.idx = idx;
      v.exp_data = e;
      v.exp_data_nb = e_nb;
      return v;
   endfunction

   function automatic logic [7:0] with_dp(input logic [7:0] e, input int unsigned idx,
                                          input logic [6:0] msec);
      logic [7:0] r;
      r = e;
`ifdef WATCH_FND_DP_BLINK_EN
      if (idx == 2 && msec < 7'd50 && e != 8'hFF) r[7] = 1'b0;
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Call at a negedge. Returns at the first negedge of the target digit slot.
   // At least one posedge separates the call from the return.
   task automatic wait_digit(input int unsigned idx);
      logic [3:0] target;
      int n;
      target = ~(4'b0001 << idx);
      n = 0;
      while (fnd_com == target && n < 40) begin @(negedge clk); n++; end
      while (fnd_com != target && n < 40) begin @(negedge clk); n++; end
      if (fnd_com != target) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_digit%0d: got com %b expected %b (timeout)", idx, fnd_com, target);
      end
   endtask

   initial begin
      rst = 1'b0; sw_mode = 1'b0;
      i_msec = '0; i_sec = '0; i_min = '0; i_hour = '0;

      vecs.push_back(mk(0,  0,  0, 47, 13, 0, 8'hF8, 8'hF8));
      vecs.push_back(mk(0,  0,  0, 47, 13, 1, 8'h99, 8'h99));
      vecs.push_back(mk(0,  0,  0, 47, 13, 2, 8'hB0, 8'hB0));
      vecs.push_back(mk(0,  0,  0, 47, 13, 3, 8'hF9, 8'hF9));
      vecs.push_back(mk(0,  0,  0,  5,  9, 3, 8'hFF, 8'hC0));
      vecs.push_back(mk(0,  0,  0,  5,  9, 2, 8'h90, 8'h90));
      vecs.push_back(mk(0,  0,  0,  5,  9, 1, 8'hC0, 8'hC0));
      vecs.push_back(mk(0,  0,  0,  5,  9, 0, 8'h92, 8'h92));
      vecs.push_back(mk(1, 100, 59, 0,  0, 0, 8'hC0, 8'hC0));
      vecs.push_back(mk(1, 100, 59, 0,  0, 1, 8'hC0, 8'hC0));
      vecs.push_back(mk(1, 100, 59, 0,  0, 2, 8'h90, 8'h90));
      vecs.push_back(mk(1, 100, 59, 0,  0, 3, 8'h92, 8'h92));
      vecs.push_back(mk(1, 127,  0, 0,  0, 0, 8'hF8, 8'hF8));
      vecs.push_back(mk(1, 127,  0, 0,  0, 1, 8'hA4, 8'hA4));
      vecs.push_back(mk(1, 127,  0, 0,  0, 3, 8'hC0, 8'hC0));
      vecs.push_back(mk(0, 49,   0, 59, 23, 2, 8'hB0, 8'hB0));
      vecs.push_back(mk(0, 49,   0, 59, 23, 3, 8'hA4, 8'hA4));
      vecs.push_back(mk(1, 50,   8, 0,  0, 2, 8'h80, 8'h80));
      vecs.push_back(mk(1, 49,   6, 0,  0, 2, 8'h82, 8'h82));
      vecs.push_back(mk(0,  0,   0, 0, 10, 3, 8'hF9, 8'hF9));
      vecs.push_back(mk(0,  0,   0, 0, 10, 0, 8'hC0, 8'hC0));

      // Reset values hold while rst is low.
      @(negedge clk); @(negedge clk);
      check("reset_com", {4'h0, fnd_com}, 8'h0F);
      check("reset_data", fnd_data, 8'hFF);

      // Scan order after release: each digit slot lasts 4 clocks.
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         check($sformatf("scan%0d", k), {4'h0, fnd_com},
               {4'h0, ~(4'b0001 << ((k / 4) % 4))});
         @(negedge clk);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         sw_mode = vecs[i].mode; i_msec = vecs[i].msec; i_sec = vecs[i].sec;
         i_min = vecs[i].min; i_hour = vecs[i].hour;
         wait_digit(vecs[i].idx);
         check($sformatf("vec%0d_data", i), fnd_data,
               with_dp(vecs[i].exp_data, vecs[i].idx, vecs[i].msec));
         check($sformatf("vec%0d_data_nb", i), fnd_data_nb,
               with_dp(vecs[i].exp_data_nb, vecs[i].idx, vecs[i].msec));
      end

      // A mode change mid-slot reaches the data one clock later. The digit
      // enable stays the same.
      sw_mode = 1'b1; i_msec = 7'd100; i_sec = 6'd59; i_min = 6'd47; i_hour = 5'd13;
      wait_digit(0);
      check("mode_before", fnd_data, 8'hC0);
      sw_mode = 1'b0;
      #1;
      check("mode_same_cycle", fnd_data, 8'hC0);
      @(negedge clk);
      check("mode_after", fnd_data, 8'hF8);
      check("mode_com", {4'h0, fnd_com}, 8'h0E);

      // Reset during slot 2 takes effect asynchronously. The scan then
      // restarts at digit 0 with a full slot.
      wait_digit(2);
      rst = 1'b0;
      #1;
      check("midrst_com", {4'h0, fnd_com}, 8'h0F);
      check("midrst_data", fnd_data, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("restart%0d", k), {4'h0, fnd_com}, (k < 4) ? 8'h0E : 8'h0D);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
